// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU issue block: MIPS opcodes/functs,
// ALU control words, exception codes and the decoder output bundle.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] CTRL_SLL = 4'b0000;
  localparam logic [3:0] CTRL_SRL = 4'b0010;
  localparam logic [3:0] CTRL_SRA = 4'b0011;
  localparam logic [3:0] CTRL_SLT = 4'b0101;
  localparam logic [3:0] CTRL_ADD = 4'b1000;
  localparam logic [3:0] CTRL_SUB = 4'b1001;
  localparam logic [3:0] CTRL_AND = 4'b1100;
  localparam logic [3:0] CTRL_OR  = 4'b1101;
  localparam logic [3:0] CTRL_NOR = 4'b1110;
  localparam logic [3:0] CTRL_XOR = 4'b1111;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_ILL  = 2'b10;

  typedef enum logic [1:0] {A_RS, A_SHAMT, A_C16} a_sel_e;
  typedef enum logic {B_RT, B_IMM} b_sel_e;
  typedef enum logic {EXT_ZERO, EXT_SIGN} ext_e;
  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_e;

  typedef struct packed {
    logic [3:0] ctrl;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    ext_e       imm_ext;
    logic       wr;
    br_e        br;
    logic       trap;
    logic       illegal;
  } dec_t;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input ext_e ext);
    return (ext == EXT_SIGN) ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational MIPS op/funct decoder producing the ALU control word and
// operand/write/branch steering for the issue stage.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec         = '0;
    o_dec.ctrl    = CTRL_ADD;
    o_dec.a_sel   = A_RS;
    o_dec.b_sel   = B_RT;
    o_dec.imm_ext = EXT_ZERO;
    o_dec.br      = BR_NONE;
    o_dec.wr      = 1'b1;
    o_dec.trap    = 1'b0;
    o_dec.illegal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_SLL:  begin o_dec.ctrl = CTRL_SLL; o_dec.a_sel = A_SHAMT; end
          FN_SRL:  begin o_dec.ctrl = CTRL_SRL; o_dec.a_sel = A_SHAMT; end
          FN_SRA:  begin o_dec.ctrl = CTRL_SRA; o_dec.a_sel = A_SHAMT; end
          FN_SLLV: o_dec.ctrl = CTRL_SLL;
          FN_SRLV: o_dec.ctrl = CTRL_SRL;
          FN_SRAV: o_dec.ctrl = CTRL_SRA;
          FN_ADD:  begin o_dec.ctrl = CTRL_ADD; o_dec.trap = 1'b1; end
          FN_ADDU: o_dec.ctrl = CTRL_ADD;
          FN_SUB:  begin o_dec.ctrl = CTRL_SUB; o_dec.trap = 1'b1; end
          FN_SUBU: o_dec.ctrl = CTRL_SUB;
          FN_AND:  o_dec.ctrl = CTRL_AND;
          FN_OR:   o_dec.ctrl = CTRL_OR;
          FN_XOR:  o_dec.ctrl = CTRL_XOR;
          FN_NOR:  o_dec.ctrl = CTRL_NOR;
          FN_SLT:  o_dec.ctrl = CTRL_SLT;
          default: begin o_dec.illegal = 1'b1; o_dec.wr = 1'b0; end
        endcase
      end
      OP_BEQ: begin o_dec.ctrl = CTRL_SUB; o_dec.br = BR_EQ; o_dec.wr = 1'b0; end
      OP_BNE: begin o_dec.ctrl = CTRL_SUB; o_dec.br = BR_NE; o_dec.wr = 1'b0; end
      OP_ADDI: begin
        o_dec.ctrl = CTRL_ADD; o_dec.b_sel = B_IMM; o_dec.imm_ext = EXT_SIGN;
        o_dec.trap = 1'b1;
      end
      OP_ADDIU: begin
        o_dec.ctrl = CTRL_ADD; o_dec.b_sel = B_IMM; o_dec.imm_ext = EXT_SIGN;
      end
      OP_SLTI: begin
        o_dec.ctrl = CTRL_SLT; o_dec.b_sel = B_IMM; o_dec.imm_ext = EXT_SIGN;
      end
      OP_ANDI: begin o_dec.ctrl = CTRL_AND; o_dec.b_sel = B_IMM; end
      OP_ORI:  begin o_dec.ctrl = CTRL_OR;  o_dec.b_sel = B_IMM; end
      OP_XORI: begin o_dec.ctrl = CTRL_XOR; o_dec.b_sel = B_IMM; end
      // LUI rides the barrel shifter: zext(imm) << 16
      OP_LUI: begin o_dec.ctrl = CTRL_SLL; o_dec.a_sel = A_C16; o_dec.b_sel = B_IMM; end
      default: begin o_dec.illegal = 1'b1; o_dec.wr = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// EX-stage issue: drives the external ALU from the ID slot and captures its
// result, branch outcome and exception into a valid/ready EX/MEM register.
module alu_issue
  import alu_pkg::*;
#(
  parameter logic TRAP_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [5:0]  i_op,
  input  logic [5:0]  i_funct,
  input  logic [4:0]  i_shamt,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic [15:0] i_imm,
  input  logic [4:0]  i_dst,
  input  logic        i_flush,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [3:0]  o_alu_ctrl,
  output logic [4:0]  o_alu_sa,
  input  logic [31:0] i_alu_res,
  input  logic        i_alu_zero,
  input  logic        i_alu_ovf,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_res,
  output logic [4:0]  o_dst,
  output logic        o_wr_en,
  output logic        o_br_taken,
  output logic [1:0]  o_exc
);

  dec_t dec;

  alu_ctrl_dec u_dec (
    .i_op    (i_op),
    .i_funct (i_funct),
    .o_dec   (dec)
  );

  always_comb begin
    case (dec.a_sel)
      A_SHAMT: o_alu_a = {27'b0, i_shamt};
      A_C16:   o_alu_a = 32'd16;
      default: o_alu_a = i_rs_val;
    endcase
    o_alu_b    = (dec.b_sel == B_IMM) ? ext_imm(i_imm, dec.imm_ext) : i_rt_val;
    o_alu_ctrl = dec.ctrl;
    o_alu_sa   = i_shamt;
  end

  logic        valid_reg;
  logic [31:0] res_reg, res_next;
  logic [4:0]  dst_reg;
  logic        wr_reg, wr_next;
  logic        br_reg, br_next;
  logic [1:0]  exc_reg, exc_next;
  logic        ovf_trap;
  logic        load;

  assign o_ready  = ~valid_reg | i_ready;
  assign load     = i_valid & o_ready;
  assign ovf_trap = TRAP_EN & dec.trap & i_alu_ovf;

  always_comb begin
    res_next = dec.illegal ? 32'd0 : i_alu_res;
    exc_next = dec.illegal ? EXC_ILL : (ovf_trap ? EXC_OVF : EXC_NONE);
    wr_next  = dec.wr & ~dec.illegal & ~ovf_trap & (i_dst != 5'd0);
    br_next  = ((dec.br == BR_EQ) & i_alu_zero) | ((dec.br == BR_NE) & ~i_alu_zero);
  end

  // Data registers only move on load, which keeps them frozen during a stall
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_reg <= 1'b0;
      res_reg   <= 32'd0;
      dst_reg   <= 5'd0;
      wr_reg    <= 1'b0;
      br_reg    <= 1'b0;
      exc_reg   <= EXC_NONE;
    end else if (i_flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      res_reg   <= res_next;
      dst_reg   <= i_dst;
      wr_reg    <= wr_next;
      br_reg    <= br_next;
      exc_reg   <= exc_next;
    end else if (i_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_valid    = valid_reg;
  assign o_res      = res_reg;
  assign o_dst      = dst_reg;
  assign o_wr_en    = wr_reg;
  assign o_br_taken = br_reg;
  assign o_exc      = exc_reg;

endmodule
